param_fifo: RTL and testbench

Parametrised synchronous first-word-fall-through FIFO, the generalised replacement for the fixed two-entry 16-bit buffer used between CNN layer stages and FIR tap outputs. Width, depth and almost-full threshold are configurable. It adds an occupancy count, an almost-full flag for early back-pressure to upstream producers, and optional sticky overflow/underflow error flags. It sits on every inter-stage data path where a producer and consumer share one clock.

---
 rtl/param_fifo_if.sv | 25 ++
 rtl/param_fifo.sv | 65 ++++++
 tb/tb_param_fifo.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/param_fifo_if.sv
// param_fifo_if: producer/consumer handshake and status bundle for param_fifo
interface param_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic             wen_i;
  logic             ren_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic             full_o;
  logic             empty_o;
  logic             almost_full_o;
  logic [CW-1:0]    count_o;
  logic             overflow_o;
  logic             underflow_o;
  modport master (
    output wen_i, ren_i, data_i,
    input  data_o, full_o, empty_o, almost_full_o, count_o, overflow_o, underflow_o
  );
  modport slave (
    input  wen_i, ren_i, data_i,
    output data_o, full_o, empty_o, almost_full_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/param_fifo.sv
// param_fifo: parametrised FWFT FIFO with count, almost-full and optional sticky
// error flags (enabled by defining PARAM_FIFO_ERR_FLAGS_EN)
module param_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input logic          clk_i,
  input logic          reset_n_i,
  param_fifo_if.slave  f
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, wr_fire, rd_fire;
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign wr_fire = f.wen_i && (!full || f.ren_i);
  assign rd_fire = f.ren_i && !empty;
  // occupancy moves only when exactly one side fires
  always_comb begin
    count_d = count_q + CW'(wr_fire) - CW'(rd_fire);
  end
  // storage, pointers and count; memory is cleared so data_o reads 0 after reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) begin
        mem_q[wr_ptr_q] <= f.data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end
  assign f.data_o        = mem_q[rd_ptr_q];
  assign f.full_o        = full;
  assign f.empty_o       = empty;
  assign f.almost_full_o = count_q >= CW'(AF_THRESH);
  assign f.count_o       = count_q;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic ov_q, uf_q;
  // sticky capture of dropped writes and ignored reads, cleared only by reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ov_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      if (f.wen_i && full && !f.ren_i) ov_q <= 1'b1;
      if (f.ren_i && empty && !f.wen_i) uf_q <= 1'b1;
    end
  end
  assign f.overflow_o  = ov_q;
  assign f.underflow_o = uf_q;
`else
  assign f.overflow_o  = 1'b0;
  assign f.underflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed table-driven bench for param_fifo (WIDTH=16, DEPTH=4)
module tb_param_fifo;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  param_fifo_if #(.WIDTH(16), .DEPTH(4)) bus ();
  param_fifo #(.WIDTH(16), .DEPTH(4), .AF_THRESH(3)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .f         (bus.slave)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic        wen;
    logic        ren;
    logic [15:0] din;
    logic [15:0] dout;
    logic [2:0]  cnt;
    logic        e;
    logic        fu;
    logic        af;
    logic        ov;
  } vec_t;
  vec_t vec [21];
  logic [15:0] q [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " data"}, 32'(bus.data_o), 0);
    chk({tag, " empty"}, 32'(bus.empty_o), 1);
    chk({tag, " full"}, 32'(bus.full_o), 0);
    chk({tag, " af"}, 32'(bus.almost_full_o), 0);
    chk({tag, " count"}, 32'(bus.count_o), 0);
    chk({tag, " ov"}, 32'(bus.overflow_o), 0);
    chk({tag, " uf"}, 32'(bus.underflow_o), 0);
  endtask
  task automatic cyc(input logic w, input logic r, input logic [15:0] d);
    bus.wen_i = w;
    bus.ren_i = r;
    bus.data_i = d;
    @(posedge clk_i);
    #1;
    bus.wen_i = 1'b0;
    bus.ren_i = 1'b0;
  endtask
  initial begin
    bus.wen_i = 1'b0;
    bus.ren_i = 1'b0;
    bus.data_i = '0;
    // wen ren din | dout cnt e f af ov(if enabled)
    vec[0]  = '{1, 0, 16'h000A, 16'h000A, 3'd1, 0, 0, 0, 0};
    vec[1]  = '{0, 1, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0};
    vec[2]  = '{1, 0, 16'h0001, 16'h0001, 3'd1, 0, 0, 0, 0};
    vec[3]  = '{1, 0, 16'h0002, 16'h0001, 3'd2, 0, 0, 0, 0};
    vec[4]  = '{1, 0, 16'h0003, 16'h0001, 3'd3, 0, 0, 1, 0};
    vec[5]  = '{1, 0, 16'h0004, 16'h0001, 3'd4, 0, 1, 1, 0};
    vec[6]  = '{1, 0, 16'h0005, 16'h0001, 3'd4, 0, 1, 1, 1};
    vec[7]  = '{0, 1, 16'h0000, 16'h0002, 3'd3, 0, 0, 1, 1};
    vec[8]  = '{0, 1, 16'h0000, 16'h0003, 3'd2, 0, 0, 0, 1};
    vec[9]  = '{0, 1, 16'h0000, 16'h0004, 3'd1, 0, 0, 0, 1};
    vec[10] = '{0, 1, 16'h0000, 16'h0001, 3'd0, 1, 0, 0, 1};
    vec[11] = '{1, 0, 16'h0001, 16'h0001, 3'd1, 0, 0, 0, 1};
    vec[12] = '{1, 0, 16'h0002, 16'h0001, 3'd2, 0, 0, 0, 1};
    vec[13] = '{1, 0, 16'h0003, 16'h0001, 3'd3, 0, 0, 1, 1};
    vec[14] = '{1, 0, 16'h0004, 16'h0001, 3'd4, 0, 1, 1, 1};
    vec[15] = '{1, 1, 16'h0009, 16'h0002, 3'd4, 0, 1, 1, 1};
    vec[16] = '{0, 1, 16'h0000, 16'h0003, 3'd3, 0, 0, 1, 1};
    vec[17] = '{0, 1, 16'h0000, 16'h0004, 3'd2, 0, 0, 0, 1};
    vec[18] = '{0, 1, 16'h0000, 16'h0009, 3'd1, 0, 0, 0, 1};
    vec[19] = '{0, 1, 16'h0000, 16'h0002, 3'd0, 1, 0, 0, 1};
    vec[20] = '{1, 1, 16'h0007, 16'h0007, 3'd1, 0, 0, 0, 1};
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset("reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 21; i++) begin
      cyc(vec[i].wen, vec[i].ren, vec[i].din);
      chk($sformatf("v%0d data", i), 32'(bus.data_o), 32'(vec[i].dout));
      chk($sformatf("v%0d count", i), 32'(bus.count_o), 32'(vec[i].cnt));
      chk($sformatf("v%0d empty", i), 32'(bus.empty_o), 32'(vec[i].e));
      chk($sformatf("v%0d full", i), 32'(bus.full_o), 32'(vec[i].fu));
      chk($sformatf("v%0d af", i), 32'(bus.almost_full_o), 32'(vec[i].af));
      chk($sformatf("v%0d ov", i), 32'(bus.overflow_o), 32'(vec[i].ov & ERR));
      chk($sformatf("v%0d uf", i), 32'(bus.underflow_o), 0);
    end
    q.push_back(16'h0007);
    cyc(1, 0, 16'h0100);
    q.push_back(16'h0100);
    chk("pre-wrap count", 32'(bus.count_o), 2);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 16'(16'h0200 + i));
      q.push_back(16'(16'h0200 + i));
      void'(q.pop_front());
      chk($sformatf("wrap%0d data", i), 32'(bus.data_o), 32'(q[0]));
      chk($sformatf("wrap%0d count", i), 32'(bus.count_o), 2);
    end
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_reset("async reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    cyc(0, 1, 16'h0000);
    chk("pop empty uf", 32'(bus.underflow_o), 32'(ERR));
    chk("pop empty count", 32'(bus.count_o), 0);
    chk("pop empty empty", 32'(bus.empty_o), 1);
    cyc(0, 0, 16'h0000);
    chk("uf sticky", 32'(bus.underflow_o), 32'(ERR));
    for (int i = 0; i < 4; i++) cyc(1, 0, 16'(16'h0030 + i));
    chk("fill full", 32'(bus.full_o), 1);
    chk("fill ov clear", 32'(bus.overflow_o), 0);
    cyc(1, 0, 16'h00FF);
    chk("write full ov", 32'(bus.overflow_o), 32'(ERR));
    chk("write full count", 32'(bus.count_o), 4);
    chk("write full head", 32'(bus.data_o), 32'h30);
    chk("uf still sticky", 32'(bus.underflow_o), 32'(ERR));
    cyc(0, 0, 16'h0000);
    chk("ov sticky", 32'(bus.overflow_o), 32'(ERR));
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_reset("final reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
